// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: pipeline sequencer for the 5-stage MIPS core.
//   Generates the stall/bubble pair for each pipeline register and the PC hold.
//   Resolves data-memory wait, branch redirect, load-use and mult/div hazards, and jump redirect.
//   Tracks mult/div occupancy and keeps saturating stall/flush performance counters.
// Ports:
//   clk, rst                               clock (rising edge), asynchronous active-high reset
//   id_rs, id_rt, id_uses_rs, id_uses_rt   source operands of the ID instruction
//   ex_mem_read, ex_rd                     load flag and destination of the EX instruction
//   ex_branch_taken, id_jump               redirect requests from EX / ID
//   id_md_start, id_md_read                mult/div start and mfhi/mflo in ID
//   dmem_wait                              data memory not ready
//   pc_stall, *_stall, *_bubble            pipeline register controls (combinational)
//   md_busy, md_done                       mult/div occupancy and completion pulse
//   stall_cycles, flush_count              saturating performance counters
module hazard_ctrl_unit #(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             id_jump,
    input  logic             id_md_start,
    input  logic             id_md_read,
    input  logic             dmem_wait,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_bubble,
    output logic             id_ex_stall,
    output logic             id_ex_bubble,
    output logic             ex_mem_stall,
    output logic             ex_mem_bubble,
    output logic             mem_wb_stall,
    output logic             mem_wb_bubble,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);
    localparam int MD_W = $clog2(MD_LATENCY + 1);
    logic [MD_W-1:0]  md_cnt_q, md_cnt_d;
    logic             md_done_q, md_done_d;
    logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
    logic             load_use, md_hazard, p1, p2, p3, p4, md_start_ok;
    always_comb begin
        load_use  = ex_mem_read && ex_rd != 5'd0 &&
                    ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
        md_busy   = md_cnt_q != '0;
        md_hazard = md_busy && (id_md_read || id_md_start);
        // Priority chain; each level is masked by every level above it and by reset.
        p1 = !rst && dmem_wait;
        p2 = !rst && !p1 && ex_branch_taken;
        p3 = !rst && !p1 && !p2 && (load_use || md_hazard);
        p4 = !rst && !p1 && !p2 && !p3 && id_jump;
        pc_stall      = p1 || p3;
        if_id_stall   = p1 || p3;
        if_id_bubble  = p2 || p4;
        id_ex_stall   = p1;
        id_ex_bubble  = p2 || p3;
        ex_mem_stall  = p1;
        ex_mem_bubble = 1'b0;
        mem_wb_stall  = p1;
        mem_wb_bubble = 1'b0;
        // A jump does not block the start; a start while busy is itself a P3 hazard.
        md_start_ok = id_md_start && !p1 && !p2 && !p3;
        // The unit keeps counting through memory wait since it runs independently.
        md_cnt_d  = md_start_ok ? MD_W'(MD_LATENCY) : md_busy ? md_cnt_q - 1'b1 : md_cnt_q;
        md_done_d = md_cnt_q == MD_W'(1);
        stall_d   = (pc_stall && stall_q != '1) ? stall_q + 1'b1 : stall_q;
        flush_d   = ((p2 || p4) && flush_q != '1) ? flush_q + 1'b1 : flush_q;
        md_done      = md_done_q;
        stall_cycles = stall_q;
        flush_count  = flush_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_cnt_q  <= '0;
            md_done_q <= 1'b0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            md_cnt_q  <= md_cnt_d;
            md_done_q <= md_done_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: scoreboard bench for hazard_ctrl_unit.
module tb_hazard_ctrl_unit;
    localparam int CW  = 6;
    localparam int MDL = 32;
    localparam logic [CW-1:0] MAXC = '1;
    // Control vector: {pc, ifid_s, ifid_b, idex_s, idex_b, exmem_s, exmem_b, memwb_s, memwb_b}
    localparam logic [8:0] NONE = 9'b000000000;
    localparam logic [8:0] FRZ  = 9'b110101010;
    localparam logic [8:0] BR   = 9'b001010000;
    localparam logic [8:0] LU   = 9'b110010000;
    localparam logic [8:0] JMP  = 9'b001000000;

    logic clk = 1'b0, rst = 1'b0;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic id_uses_rs, id_uses_rt, ex_mem_read, ex_branch_taken, id_jump, id_md_start, id_md_read, dmem_wait;
    logic pc_stall, if_id_stall, if_id_bubble, id_ex_stall, id_ex_bubble;
    logic ex_mem_stall, ex_mem_bubble, mem_wb_stall, mem_wb_bubble, md_busy, md_done;
    logic [CW-1:0] stall_cycles, flush_count;
    logic [8:0] ctl, cur, e;
    logic [8:0] sbq[$];
    logic [CW-1:0] es, ef;
    int checks = 0, errors = 0;

    hazard_ctrl_unit #(.MD_LATENCY(MDL), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken), .id_jump(id_jump), .id_md_start(id_md_start),
        .id_md_read(id_md_read), .dmem_wait(dmem_wait), .pc_stall(pc_stall),
        .if_id_stall(if_id_stall), .if_id_bubble(if_id_bubble), .id_ex_stall(id_ex_stall),
        .id_ex_bubble(id_ex_bubble), .ex_mem_stall(ex_mem_stall), .ex_mem_bubble(ex_mem_bubble),
        .mem_wb_stall(mem_wb_stall), .mem_wb_bubble(mem_wb_bubble), .md_busy(md_busy),
        .md_done(md_done), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;
    assign ctl = {pc_stall, if_id_stall, if_id_bubble, id_ex_stall, id_ex_bubble,
                  ex_mem_stall, ex_mem_bubble, mem_wb_stall, mem_wb_bubble};

    // Reference performance counters driven by the expected control vector of each cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            es <= '0;
            ef <= '0;
        end else begin
            if (cur[8] && es != MAXC) es <= es + 1'b1;
            if ((cur == BR || cur == JMP) && ef != MAXC) ef <= ef + 1'b1;
        end
    end

    task automatic idle();
        id_rs = 0; id_rt = 0; ex_rd = 0; id_uses_rs = 0; id_uses_rt = 0; ex_mem_read = 0;
        ex_branch_taken = 0; id_jump = 0; id_md_start = 0; id_md_read = 0; dmem_wait = 0;
        cur = NONE;
    endtask

    task automatic load_use_in();
        ex_mem_read = 1; ex_rd = 5; id_rs = 5; id_uses_rs = 1; id_rt = 1; id_uses_rt = 1;
    endtask

    // Record the expected control vector for the cycle just driven, then let it settle.
    task automatic push(input logic [8:0] x);
        cur = x;
        sbq.push_back(x);
        #2;
    endtask

    task automatic test_reset();
        idle(); load_use_in(); dmem_wait = 1;
        #1 rst = 1;
        @(negedge clk); push(NONE);
        e = sbq.pop_front(); checks++;
        if (ctl !== e) begin errors++; $display("FAIL reset_ctl got %b exp %b", ctl, e); end
        checks++;
        if ({md_busy, md_done, stall_cycles, flush_count} !== '0) begin
            errors++; $display("FAIL reset_state got busy=%b done=%b st=%0d fl=%0d exp 0", md_busy, md_done, stall_cycles, flush_count);
        end
        @(negedge clk); rst = 0; idle();
    endtask

    task automatic test_load_use();
        @(negedge clk); idle(); load_use_in(); push(LU);
        e = sbq.pop_front(); checks++;
        if (ctl !== e) begin errors++; $display("FAIL lu_ctl got %b exp %b", ctl, e); end
        @(negedge clk); idle(); push(NONE);
        e = sbq.pop_front(); checks++;
        if (ctl !== e) begin errors++; $display("FAIL lu_after got %b exp %b", ctl, e); end
        checks++;
        if (stall_cycles !== es || es !== 1) begin errors++; $display("FAIL lu_stall_cnt got %0d exp 1", stall_cycles); end
    endtask

    task automatic test_no_hazard();
        @(negedge clk); idle(); ex_mem_read = 1; ex_rd = 0; id_rs = 0; id_uses_rs = 1; push(NONE);
        e = sbq.pop_front(); checks++;
        if (ctl !== e) begin errors++; $display("FAIL r0_nostall got %b exp %b", ctl, e); end
        @(negedge clk); idle(); ex_mem_read = 1; ex_rd = 7; id_rt = 7; id_uses_rt = 0; id_rs = 3; id_uses_rs = 1; push(NONE);
        e = sbq.pop_front(); checks++;
        if (ctl !== e) begin errors++; $display("FAIL rt_unused got %b exp %b", ctl, e); end
        @(negedge clk); id_uses_rt = 1; push(LU);
        e = sbq.pop_front(); checks++;
        if (ctl !== e) begin errors++; $display("FAIL rt_used got %b exp %b", ctl, e); end
        @(negedge clk); idle(); ex_rd = 7; id_rs = 7; id_uses_rs = 1; push(NONE);
        e = sbq.pop_front(); checks++;
        if (ctl !== e) begin errors++; $display("FAIL not_load got %b exp %b", ctl, e); end
    endtask

    task automatic test_redirect();
        @(negedge clk); idle(); load_use_in(); ex_branch_taken = 1; push(BR);
        e = sbq.pop_front(); checks++;
        if (ctl !== e) begin errors++; $display("FAIL br_over_lu got %b exp %b", ctl, e); end
        @(negedge clk); idle(); id_jump = 1; push(JMP);
        e = sbq.pop_front(); checks++;
        if (ctl !== e) begin errors++; $display("FAIL jump got %b exp %b", ctl, e); end
        @(negedge clk); load_use_in(); push(LU);
        e = sbq.pop_front(); checks++;
        if (ctl !== e) begin errors++; $display("FAIL lu_over_jump got %b exp %b", ctl, e); end
        @(negedge clk); idle(); dmem_wait = 1; ex_branch_taken = 1; push(FRZ);
        e = sbq.pop_front(); checks++;
        if (ctl !== e) begin errors++; $display("FAIL wait_over_br got %b exp %b", ctl, e); end
        @(negedge clk); idle(); push(NONE);
        e = sbq.pop_front(); checks++;
        if (flush_count !== ef || ef !== 2) begin errors++; $display("FAIL flush_cnt got %0d exp 2", flush_count); end
        checks++;
        if (stall_cycles !== es) begin errors++; $display("FAIL redir_stall_cnt got %0d exp %0d", stall_cycles, es); end
    endtask

    task automatic test_md();
        // Start masked by a branch is discarded.
        @(negedge clk); idle(); id_md_start = 1; ex_branch_taken = 1; push(BR);
        e = sbq.pop_front(); checks++;
        if (ctl !== e) begin errors++; $display("FAIL md_start_br got %b exp %b", ctl, e); end
        @(negedge clk); idle(); push(NONE);
        e = sbq.pop_front(); checks++;
        if (md_busy !== 1'b0) begin errors++; $display("FAIL md_blocked got busy=%b exp 0", md_busy); end
        @(negedge clk); id_md_start = 1; push(NONE);
        e = sbq.pop_front(); checks++;
        if (ctl !== e) begin errors++; $display("FAIL md_start got %b exp %b", ctl, e); end
        for (int i = 0; i < MDL; i++) begin
            @(negedge clk); idle(); id_md_read = 1; push(LU);
            e = sbq.pop_front(); checks++;
            if (ctl !== e || md_busy !== 1'b1 || md_done !== 1'b0) begin
                errors++; $display("FAIL md_wait%0d got %b busy=%b done=%b exp %b busy=1 done=0", i, ctl, md_busy, md_done, e);
            end
        end
        @(negedge clk); push(NONE);
        e = sbq.pop_front(); checks++;
        if (ctl !== e || md_busy !== 1'b0 || md_done !== 1'b1) begin
            errors++; $display("FAIL md_release got %b busy=%b done=%b exp %b busy=0 done=1", ctl, md_busy, md_done, e);
        end
        @(negedge clk); idle(); push(NONE);
        e = sbq.pop_front(); checks++;
        if (md_done !== 1'b0) begin errors++; $display("FAIL md_done_pulse got %b exp 0", md_done); end
        checks++;
        if (stall_cycles !== es) begin errors++; $display("FAIL md_stall_cnt got %0d exp %0d", stall_cycles, es); end
    endtask

    task automatic test_dmem_wait();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle(); load_use_in(); dmem_wait = 1; push(FRZ);
            e = sbq.pop_front(); checks++;
            if (ctl !== e) begin errors++; $display("FAIL dmem%0d got %b exp %b", i, ctl, e); end
        end
        @(negedge clk); dmem_wait = 0; push(LU);
        e = sbq.pop_front(); checks++;
        if (ctl !== e) begin errors++; $display("FAIL dmem_resume got %b exp %b", ctl, e); end
        @(negedge clk); idle(); push(NONE);
        e = sbq.pop_front(); checks++;
        if (ctl !== e || stall_cycles !== es) begin
            errors++; $display("FAIL dmem_after got %b st=%0d exp %b st=%0d", ctl, stall_cycles, e, es);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 70; i++) begin
            @(negedge clk); idle(); dmem_wait = 1; push(FRZ);
            e = sbq.pop_front();
        end
        @(negedge clk); idle(); push(NONE);
        e = sbq.pop_front(); checks++;
        if (stall_cycles !== es || stall_cycles !== MAXC) begin
            errors++; $display("FAIL stall_sat got %0d exp %0d", stall_cycles, MAXC);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); idle(); id_md_start = 1; push(NONE);
        e = sbq.pop_front();
        for (int i = 0; i < 22; i++) begin
            @(negedge clk); idle(); push(NONE);
            e = sbq.pop_front();
        end
        @(negedge clk); id_md_read = 1; push(LU);
        e = sbq.pop_front(); checks++;
        if (ctl !== e || md_busy !== 1'b1) begin errors++; $display("FAIL pre_rst got %b busy=%b exp %b busy=1", ctl, md_busy, e); end
        #1 rst = 1; push(NONE);
        e = sbq.pop_front(); checks++;
        if (ctl !== e || {md_busy, md_done, stall_cycles, flush_count} !== '0) begin
            errors++; $display("FAIL async_rst got %b busy=%b done=%b st=%0d fl=%0d exp all 0", ctl, md_busy, md_done, stall_cycles, flush_count);
        end
        @(negedge clk); rst = 0; idle(); push(NONE);
        e = sbq.pop_front();
        @(negedge clk); push(NONE);
        e = sbq.pop_front(); checks++;
        if (md_busy !== 1'b0 || md_done !== 1'b0) begin errors++; $display("FAIL md_discarded got busy=%b done=%b exp 0 0", md_busy, md_done); end
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_no_hazard();
        test_redirect();
        test_md();
        test_dmem_wait();
        test_saturate();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
